mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit for the MEM stage of the pipelined MIPS core. It is the data-side counterpart of the immediate extender: it packs store data into byte lanes, issues a handshaked word-aligned bus cycle, and extracts and sign- or zero-extends load data (lb/lbu/lh/lhu/lw). The CPU pipeline stalls while a request is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of BUS-state cycles to wait for `mem_ack` before the access is aborted.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU access request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word accesses and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies `rsp_valid`: misaligned address, illegal size, or timeout.
- mem_en  out  1  bus cycle active.
- mem_we  out  1  bus write.
- mem_be  out  4  byte enables; bit k selects `data[8k+7:8k]`.
- mem_addr  out  32  `{req_addr[31:2], 2'b00}`.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states and transitions:
  - IDLE to BUS when a request is accepted and it is legal.
  - IDLE to RESP when a request is accepted and it is misaligned or has an illegal size.
  - BUS to RESP on `mem_ack`, or on timeout.
  - RESP to IDLE unconditionally.
- Acceptance: `req_valid && req_ready`. Address, size, unsigned flag and data are registered at acceptance and are not resampled afterwards.
- Legality checks:
  - Halfword requires `addr[0] == 0`.
  - Word requires `addr[1:0] == 0`.
  - `req_size == 11` is illegal.
  - Any failure: no bus cycle is issued and the response carries `rsp_err = 1`.
- Store lane packing (little-endian, k = `addr[1:0]`):
  - Byte: `be = 1 << k`, `wdata = {4{b}}`.
  - Half: `be = 0011` if `addr[1] == 0`, else `1100`; `wdata = {2{h}}`.
  - Word: `be = 1111`, `wdata` unchanged.
- Loads: `mem_we = 0` and `mem_be` is computed as for stores. On ack:
  - Byte: take lane k, extend to 32 bits.
  - Half: take lane `addr[1]`, extend to 32 bits.
  - Word: pass through unchanged.
  - Extension is sign extension unless `req_unsigned` is set, in which case it is zero extension.
- Timeout:
  - A counter clears on entering BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, `mem_en` drops, state goes to RESP, and `rsp_err = 1`.
  - An ack arriving in that same cycle takes priority; the access succeeds.
- `mem_ack` outside BUS is ignored.

## Timing
- All outputs are registered.
- Reset values: `req_ready = 1` (IDLE); `rsp_valid`, `rsp_err`, `mem_en`, `mem_we` = 0; `mem_be` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Request accepted at edge T: `mem_en` and its qualifiers are asserted from T+1 and held stable until the ack is sampled.
- Ack at cycle T+n (n ≥ 1): `mem_en` drops, and `rsp_valid` pulses in the next cycle with the data.
- Minimum latency from acceptance to response is 2 cycles; the bus sees one cycle per access.
- Error path (misaligned or illegal size): `rsp_valid` pulses at T+1 and `mem_en` is never asserted.
- `req_ready` is low from T+1 through the RESP cycle. The next request can be accepted in the cycle after RESP.
- Reset mid-access: the unit is in IDLE with all outputs at reset values after the edge. There is no response for the aborted access, and a late `mem_ack` is ignored.

## Structure
- Shared package `mem_pkg` holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - FSM state encodings (IDLE/BUS/RESP);
  - the byte-enable constants for the half lanes (0011/1100) and word (1111).
- The lane-select and extend logic is a combinational sub-module `load_extract` (inputs `rdata`, `addr[1:0]`, `size`, `unsigned`; output 32-bit result). The unit instantiates it once.

## Test plan
- lb, `addr = 0x1003`, `mem_rdata = 0x80FF_1234`, ack after 1 cycle → `mem_be = 1000`, `mem_addr = 0x1000`, `rsp_rdata = 0xFFFF_FF80`; repeated as lbu → `0x0000_0080`.
- sh, `addr = 0x2002`, `wdata = 0xDEAD_BEEF` → `mem_be = 1100`, `mem_wdata = 0xBEEF_BEEF`, `mem_we = 1`; `rsp_valid` with `rsp_err = 0`, `rsp_rdata = 0`.
- lw at `0x3001` → `rsp_valid` at T+1 with `rsp_err = 1`, `mem_en` never high.
- lh `0x4000`, ack withheld, TIMEOUT_CYCLES = 4 → `mem_en` high for exactly 4 cycles, then `rsp_err = 1`; a late ack afterwards is ignored.
- Back-to-back lw `0x10` then sw `0x14`, ack with 0 wait cycles → second request accepted the cycle after the first RESP; each request gets exactly one `rsp_valid`.
- `reset` asserted during BUS → IDLE next cycle, all outputs at reset values, no `rsp_valid` pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data access unit.
// Used by both the access FSM and the load extract logic.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // A request is legal when its size is defined and its address is naturally aligned.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lsb[0];
      SZ_WORD: ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lsb;
      SZ_HALF: be = lsb[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{wdata[7:0]}};
      SZ_HALF: wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half lane from a bus read word and extends it
// to 32 bits; word loads pass straight through.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lsb,
  input  logic [1:0]  size,
  input  logic        unsigned_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[8*addr_lsb +: 8];
    half_lane = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{~unsigned_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{~unsigned_ext & half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: packs stores into byte lanes, runs one
// handshaked word-aligned bus cycle with timeout, and extends load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lsb_q, lsb_d;
  logic [1:0]    size_q, size_d;
  logic          unsigned_q, unsigned_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   load_data;

  load_extract u_load_extract (
    .rdata        (mem_rdata),
    .addr_lsb     (lsb_q),
    .size         (size_q),
    .unsigned_ext (unsigned_q),
    .result       (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lsb_d       = lsb_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          lsb_d       = req_addr[1:0];
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          req_ready_d = 1'b0;
          if (req_legal(req_size, req_addr[1:0])) begin
            state_d     = BUS;
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_be_d    = lane_be(req_size, req_addr[1:0]);
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata(req_size, req_wdata);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      BUS: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack || (cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES))) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~mem_ack;
          rsp_rdata_d = (mem_ack && !mem_we_q) ? load_data : 32'd0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lsb_q       <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lsb_q       <= lsb_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus random bench for mem_access_unit, checked against an
// arithmetic model of lane packing, load extension and timeout.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_be"}, mem_be, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One access from the reference model's point of view. Called just after a
  // falling edge with the unit idle; returns just after a falling edge, idle.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rd);
    int      nbytes, k, en_cycles;
    bit      legal, acked;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, mask;

    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    k      = int'(addr % 4);
    legal  = (size != 2'd3) && ((addr % nbytes) == 0);
    ebe    = 4'(((1 << nbytes) - 1) << k);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nbytes)) - 1);
    ewd    = (nbytes == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
             (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    erd    = (rd >> (8 * k)) & mask;
    if (nbytes < 4 && !uns && erd >= ((mask >> 1) + 1)) erd = erd | ~mask;

    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_we = 1'($urandom);
    @(negedge clk);
    acked = 1'b0;
    en_cycles = 0;
    if (legal) begin
      check("ready_low_in_bus", req_ready, 0);
      check("mem_we", mem_we, we);
      check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (we) check("mem_wdata", mem_wdata, ewd);
      for (int i = 0; i < TO; i++) begin
        if (i > 0) @(negedge clk);
        en_cycles += int'(mem_en);
        check("mem_be_held", mem_be, ebe);
        check("no_rsp_in_bus", rsp_valid, 0);
        mem_ack   = (i == delay);
        mem_rdata = (i == delay) ? rd : $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (i == delay) begin
          acked = 1'b1;
          break;
        end
      end
      @(negedge clk);
      check("mem_en_cycles", en_cycles, acked ? delay + 1 : TO);
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, !acked);
    check("rsp_rdata", rsp_rdata, (acked && !we) ? erd : 32'd0);
    check("mem_en_resp", mem_en, 0);
    check("ready_low_resp", req_ready, 0);
    $display("access we=%0d size=%0d uns=%0d addr=%h wdata=%h delay=%0d rd=%h -> err=%0d rdata=%h",
             we, size, uns, addr, wdata, delay, rd, rsp_err, rsp_rdata);
    @(negedge clk);
    check("rsp_pulse_done", rsp_valid, 0);
    check("ready_after_resp", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // lb / lbu at top lane, one wait cycle
    do_access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234);
    do_access(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234);
    // sh upper half
    do_access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 0, 32'h1234_5678);
    // misaligned lw and illegal size
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h55, 0, 32'h0);
    // lh with ack withheld: timeout, then a stray ack in IDLE
    do_access(1'b0, 2'd1, 1'b0, 32'h0000_4000, 32'h0, 100, 32'hCAFE_F00D);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rsp", rsp_valid, 0);
    check("late_ack_en", mem_en, 0);
    check("late_ack_ready", req_ready, 1);
    // ack on the final allowed cycle beats timeout
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_4100, 32'h0, TO - 1, 32'h0BAD_CAFE);
    // back-to-back lw / sw, zero wait
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1357_9BDF);
    do_access(1'b1, 2'd2, 1'b0, 32'h0000_0014, 32'hA5A5_0F0F, 0, 32'h0);

    // reset while the bus cycle is outstanding
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_5000;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_mem_en", mem_en, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    $display("reset during BUS -> rsp_valid=%0d mem_en=%0d ready=%0d", rsp_valid, mem_en, req_ready);

    for (int n = 0; n < 40; n++) begin
      do_access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 5)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
